mem_wb_stage: RTL and testbench

//   MEM/WB pipeline register and writeback producer. Captures EX/MEM results and

---
 rtl/mem_wb_stage.sv | 128 ++++++++++++
 tb/tb_mem_wb_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: captures EX/MEM results and load data, extracts
// sub-word loads, selects the writeback value and counts retired instructions.
module mem_wb_stage #(
    parameter int CNT_W        = 32,
    parameter bit ZERO_PROTECT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             ex_mem_valid,
    input  logic [4:0]       ex_mem_regd,
    input  logic             ex_mem_wen,
    input  logic             ex_mem_memtoreg,
    input  logic             ex_mem_link,
    input  logic [1:0]       ex_mem_ld_size,
    input  logic             ex_mem_ld_unsigned,
    input  logic [31:0]      ex_mem_alu_result,
    input  logic [31:0]      ex_mem_pc_plus8,
    input  logic [31:0]      mem_rdata,
    output logic [4:0]       mem_wb_regd,
    output logic [31:0]      mem_wb_data,
    output logic             mem_wb_wen,
    output logic             mem_wb_valid,
    output logic [CNT_W-1:0] retired_count
);

    // Little-endian lane select followed by sign/zero extension; size 11 acts as word.
    function automatic logic [31:0] load_extract(
        input logic [31:0] rdata,
        input logic [1:0]  addr,
        input logic [1:0]  size,
        input logic        uns
    );
        logic        [7:0]  lane_b;
        logic        [15:0] lane_h;
        logic signed [31:0] ext;
        logic        [31:0] res;
        case (addr)
            2'b00:   lane_b = rdata[7:0];
            2'b01:   lane_b = rdata[15:8];
            2'b10:   lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        lane_h = addr[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'b00: begin
                ext = {{24{lane_b[7]}}, lane_b};
                res = uns ? {24'd0, lane_b} : ext;
            end
            2'b01: begin
                ext = {{16{lane_h[15]}}, lane_h};
                res = uns ? {16'd0, lane_h} : ext;
            end
            default: begin
                ext = rdata;
                res = rdata;
            end
        endcase
        return res;
    endfunction

    logic [4:0]       regd_d,  regd_q;
    logic [31:0]      data_d,  data_q;
    logic             wen_d,   wen_q;
    logic             valid_d, valid_q;
    logic [CNT_W-1:0] cnt_d,   cnt_q;
    logic [31:0]      wb_value;
    logic             wen_cap;

    always_comb begin
        if (ex_mem_link) begin
            wb_value = ex_mem_pc_plus8;
        end else if (ex_mem_memtoreg) begin
            wb_value = load_extract(mem_rdata, ex_mem_alu_result[1:0],
                                    ex_mem_ld_size, ex_mem_ld_unsigned);
        end else begin
            wb_value = ex_mem_alu_result;
        end
        wen_cap = ex_mem_wen & ex_mem_valid & ~(ZERO_PROTECT && (ex_mem_regd == 5'd0));
    end

    // Flush beats stall; stall holds everything including the retire counter.
    always_comb begin
        regd_d  = regd_q;
        data_d  = data_q;
        wen_d   = wen_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (flush) begin
            regd_d  = 5'd0;
            data_d  = 32'd0;
            wen_d   = 1'b0;
            valid_d = 1'b0;
        end else if (!stall) begin
            regd_d  = ex_mem_regd;
            data_d  = wb_value;
            wen_d   = wen_cap;
            valid_d = ex_mem_valid;
            if (ex_mem_valid) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regd_q  <= 5'd0;
            data_q  <= 32'd0;
            wen_q   <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            regd_q  <= regd_d;
            data_q  <= data_d;
            wen_q   <= wen_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign mem_wb_regd   = regd_q;
    assign mem_wb_data   = data_q;
    assign mem_wb_wen    = wen_q;
    assign mem_wb_valid  = valid_q;
    assign retired_count = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed steps plus random traffic compared against
// an arithmetic reference model; a narrow counter makes the wrap reachable.
module tb_mem_wb_stage;

    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          stall, flush;
    logic          ex_mem_valid;
    logic [4:0]    ex_mem_regd;
    logic          ex_mem_wen, ex_mem_memtoreg, ex_mem_link;
    logic [1:0]    ex_mem_ld_size;
    logic          ex_mem_ld_unsigned;
    logic [31:0]   ex_mem_alu_result, ex_mem_pc_plus8, mem_rdata;
    logic [4:0]    mem_wb_regd;
    logic [31:0]   mem_wb_data;
    logic          mem_wb_wen, mem_wb_valid;
    logic [CW-1:0] retired_count;

    mem_wb_stage #(.CNT_W(CW), .ZERO_PROTECT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .ex_mem_valid(ex_mem_valid), .ex_mem_regd(ex_mem_regd),
        .ex_mem_wen(ex_mem_wen), .ex_mem_memtoreg(ex_mem_memtoreg),
        .ex_mem_link(ex_mem_link), .ex_mem_ld_size(ex_mem_ld_size),
        .ex_mem_ld_unsigned(ex_mem_ld_unsigned),
        .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_pc_plus8(ex_mem_pc_plus8),
        .mem_rdata(mem_rdata), .mem_wb_regd(mem_wb_regd), .mem_wb_data(mem_wb_data),
        .mem_wb_wen(mem_wb_wen), .mem_wb_valid(mem_wb_valid),
        .retired_count(retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int          m_regd, m_wen, m_valid, m_cnt;
    logic [31:0] m_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference load value from shift/mask arithmetic.
    function automatic logic [31:0] ref_load(input logic [31:0] rdata, input int addr,
                                             input int size, input bit uns);
        int          bits, shift;
        logic [31:0] mask, val;
        if (size >= 2) return rdata;
        bits  = (size == 0) ? 8 : 16;
        shift = (size == 0) ? 8 * addr : 16 * (addr / 2);
        mask  = (32'd1 << bits) - 32'd1;
        val   = (rdata >> shift) & mask;
        if (!uns && val[bits-1]) val = val | ~mask;
        return val;
    endfunction

    function automatic logic [31:0] ref_wb();
        if (ex_mem_link) return ex_mem_pc_plus8;
        if (ex_mem_memtoreg)
            return ref_load(mem_rdata, int'(ex_mem_alu_result % 4), int'(ex_mem_ld_size),
                            ex_mem_ld_unsigned);
        return ex_mem_alu_result;
    endfunction

    task automatic model_reset();
        m_regd = 0; m_wen = 0; m_valid = 0; m_cnt = 0; m_data = 32'd0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".regd"},  32'(mem_wb_regd),   32'(m_regd));
        check({tag, ".data"},  mem_wb_data,        m_data);
        check({tag, ".wen"},   32'(mem_wb_wen),    32'(m_wen));
        check({tag, ".valid"}, 32'(mem_wb_valid),  32'(m_valid));
        check({tag, ".cnt"},   32'(retired_count), 32'(m_cnt));
    endtask

    // One clock edge: model the edge from the stable inputs, then sample after it.
    task automatic cycle(input string tag);
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (flush) begin
            m_regd = 0; m_wen = 0; m_valid = 0; m_data = 32'd0;
        end else if (!stall) begin
            m_regd  = int'(ex_mem_regd);
            m_data  = ref_wb();
            m_valid = int'(ex_mem_valid);
            m_wen   = (ex_mem_valid && ex_mem_wen && ex_mem_regd != 5'd0) ? 1 : 0;
            if (ex_mem_valid) m_cnt = (m_cnt + 1) % (1 << CW);
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic drive(input bit v, input int rd, input bit we, input bit m2r,
                         input bit lnk, input int sz, input bit uns,
                         input logic [31:0] alu, input logic [31:0] pc8,
                         input logic [31:0] rdata);
        ex_mem_valid = v; ex_mem_regd = 5'(rd); ex_mem_wen = we;
        ex_mem_memtoreg = m2r; ex_mem_link = lnk; ex_mem_ld_size = 2'(sz);
        ex_mem_ld_unsigned = uns; ex_mem_alu_result = alu;
        ex_mem_pc_plus8 = pc8; mem_rdata = rdata;
    endtask

    task automatic drive_random();
        drive(1'($urandom), int'($urandom_range(0, 31)), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), 1'($urandom),
              $urandom, $urandom, $urandom);
    endtask

    initial begin
        logic [31:0] held_data;
        int          held_cnt;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0);
        model_reset();
        #12;
        check_outputs("reset_initial");
        rst_n = 1'b1;

        drive(1, 5, 1, 0, 0, 2, 0, 32'h0000_1234, 32'h0, 32'h0);
        cycle("alu_op");
        check("alu_op.lit_data", mem_wb_data, 32'h0000_1234);

        drive(1, 7, 1, 1, 0, 0, 0, 32'h0000_0003, 32'h0, 32'h80FF_7F01);
        cycle("lb");
        check("lb.lit", mem_wb_data, 32'hFFFF_FF80);
        drive(1, 7, 1, 1, 0, 0, 1, 32'h0000_0003, 32'h0, 32'h80FF_7F01);
        cycle("lbu");
        check("lbu.lit", mem_wb_data, 32'h0000_0080);
        drive(1, 7, 1, 1, 0, 1, 0, 32'h0000_0002, 32'h0, 32'h80FF_7F01);
        cycle("lh");
        check("lh.lit", mem_wb_data, 32'hFFFF_80FF);
        drive(1, 7, 1, 1, 0, 1, 1, 32'h0000_0002, 32'h0, 32'h80FF_7F01);
        cycle("lhu");
        check("lhu.lit", mem_wb_data, 32'h0000_80FF);
        drive(1, 8, 1, 1, 0, 3, 0, 32'h0000_0001, 32'h0, 32'h80FF_7F01);
        cycle("lw_size11");

        drive(1, 0, 1, 0, 0, 2, 0, 32'hDEAD_BEEF, 32'h0, 32'h0);
        cycle("regd0");
        check("regd0.lit_wen", 32'(mem_wb_wen), 32'd0);

        drive(0, 9, 1, 0, 0, 2, 0, 32'h1111_2222, 32'h0, 32'h0);
        cycle("invalid");

        drive(1, 12, 1, 0, 0, 2, 0, 32'hCAFE_0001, 32'h0, 32'h0);
        cycle("pre_stall");
        held_data = m_data; held_cnt = m_cnt;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_random();
            cycle("stall");
        end
        check("stall.frozen_data", mem_wb_data, held_data);
        check("stall.frozen_cnt", 32'(retired_count), 32'(held_cnt));
        flush = 1'b1;
        drive(1, 13, 1, 0, 0, 2, 0, 32'h5555_AAAA, 32'h0, 32'h0);
        cycle("stall_flush");
        check("stall_flush.lit_valid", 32'(mem_wb_valid), 32'd0);
        flush = 1'b0;

        // Asynchronous reset landing mid-cycle while stalled.
        drive(1, 14, 1, 0, 0, 2, 0, 32'h0BAD_F00D, 32'h0, 32'h0);
        cycle("pre_reset");
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("reset_mid_stall");
        #2;
        rst_n = 1'b1;
        stall = 1'b0;
        drive(1, 31, 1, 1, 1, 0, 0, 32'h0000_0003, 32'h0040_0010, 32'hFFFF_FFFF);
        cycle("link");
        check("link.lit", mem_wb_data, 32'h0040_0010);

        for (int i = 0; i < 14; i++) begin
            drive(1, i + 1, 1, 0, 0, 2, 0, 32'(i), 32'h0, 32'h0);
            cycle("fill_cnt");
        end
        check("cnt_max.lit", 32'(retired_count), 32'd15);
        drive(1, 3, 1, 0, 0, 2, 0, 32'h0, 32'h0, 32'h0);
        cycle("cnt_wrap");
        check("cnt_wrap.lit", 32'(retired_count), 32'd0);

        for (int i = 0; i < 300; i++) begin
            drive_random();
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 7) == 0);
            cycle("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
